// File: rtl/usb3_comma_aligner.sv
// usb3_comma_aligner
//   Symbol aligner in the recovered-clock domain, feeding the USB 3.0 elastic
//   buffer. Unaligned 10-bit deserializer words are joined with the previous
//   word into a 20-bit window. All 10 bit offsets of that window are searched
//   for a K28.5 comma. The aligner locks after LOCK_CNT consecutive commas at
//   one offset. It then emits symbol-aligned words. Lock is dropped after
//   LOSS_CNT consecutive commas at a different offset.
//
// Ports
//   rclk          in   recovered clock
//   rrst          in   synchronous reset, active-high
//   data_in[9:0]  in   raw deserializer word, bit 0 received first
//   data_in_vld   in   data_in valid this cycle
//   data_out[9:0] out  aligned symbol
//   data_out_vld  out  data_out valid (only while locked)
//   comma_out     out  data_out is a K28.5 comma (qualified by data_out_vld)
//   locked        out  alignment locked
//   align_off[3:0] out current lock offset, 0..9
//   dbg_state[1:0] out aligner FSM state, for observation only
//
// Valid semantics: there is no backpressure. A word is consumed on every rclk
// edge where data_in_vld=1. Cycles with data_in_vld=0 freeze all state and
// drive data_out_vld low for one cycle while data_out holds. The output
// pipeline is a single register stage.
module usb3_comma_aligner #(
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned LOSS_CNT  = 4,
  parameter logic [9:0]  COMMA_NEG = 10'h17C,
  parameter logic [9:0]  COMMA_POS = 10'h283
) (
  input  logic       rclk,
  input  logic       rrst,
  input  logic [9:0] data_in,
  input  logic       data_in_vld,
  output logic [9:0] data_out,
  output logic       data_out_vld,
  output logic       comma_out,
  output logic       locked,
  output logic [3:0] align_off,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t      r_state;
  logic [9:0]  r_prev;
  logic        r_primed;
  logic [3:0]  r_cand_off;
  logic [3:0]  r_align_off;
  logic [2:0]  r_cnt;
  logic [2:0]  r_err;
  logic [9:0]  r_data_out;
  logic        r_data_out_vld;
  logic        r_comma_out;
  logic        r_locked;

  logic [19:0] w_win;
  logic [9:0]  w_hit;
  logic        w_hit_any;
  logic [3:0]  w_hit_off;
  state_t      w_state_n;
  logic [3:0]  w_cand_n;
  logic [3:0]  w_align_n;
  logic [2:0]  w_cnt_n;
  logic [2:0]  w_err_n;
  logic [3:0]  w_next_off;
  logic [19:0] w_shift;
  logic [9:0]  w_sym;
  logic        w_sym_comma;

  // Window: previous word occupies the low (earlier) half.
  assign w_win = {data_in, r_prev};

  // Comma search over all offsets. The first word after reset has no real
  // predecessor in r_prev, so detection waits until r_primed is set.
  always_comb begin
    w_hit     = '0;
    w_hit_off = 4'd0;
    for (int k = 0; k < 10; k++) begin
      w_hit[k] = r_primed &&
                 ((w_win[k +: 10] == COMMA_NEG) || (w_win[k +: 10] == COMMA_POS));
    end
    // Descending scan so the lowest hitting offset is the one kept.
    for (int k = 9; k >= 0; k--) begin
      if (w_hit[k]) w_hit_off = 4'(k);
    end
  end

  assign w_hit_any = |w_hit;

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    w_cand_n  = r_cand_off;
    w_align_n = r_align_off;
    w_cnt_n   = r_cnt;
    w_err_n   = r_err;
    if (data_in_vld && w_hit_any) begin
      case (r_state)
        ST_UNLOCKED: begin
          w_cand_n  = w_hit_off;
          w_cnt_n   = 3'd1;
          w_state_n = ST_CANDIDATE;
        end
        ST_CANDIDATE: begin
          if (w_hit_off == r_cand_off) begin
            w_cnt_n = r_cnt + 3'd1;
            if (w_cnt_n == 3'(LOCK_CNT)) begin
              w_state_n = ST_LOCKED;
              w_align_n = r_cand_off;
            end
          end else begin
            // A comma elsewhere restarts the confirmation count there.
            w_cand_n = w_hit_off;
            w_cnt_n  = 3'd1;
          end
        end
        ST_LOCKED: begin
          if (w_hit_off == r_align_off) begin
            w_err_n = 3'd0;
          end else begin
            w_err_n = r_err + 3'd1;
            if (w_err_n == 3'(LOSS_CNT)) begin
              // align_off deliberately keeps its last value.
              w_state_n = ST_UNLOCKED;
              w_err_n   = 3'd0;
              w_cnt_n   = 3'd0;
            end
          end
        end
        default: w_state_n = ST_UNLOCKED;
      endcase
    end
  end

  // Output symbol uses the offset held after this edge, so the comma that
  // completes lock is emitted on the same edge that locked rises.
  assign w_next_off  = (w_state_n == ST_CANDIDATE) ? w_cand_n : w_align_n;
  assign w_shift     = w_win >> w_next_off;
  assign w_sym       = w_shift[9:0];
  assign w_sym_comma = (w_sym == COMMA_NEG) || (w_sym == COMMA_POS);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state        <= ST_UNLOCKED;
      r_prev         <= 10'd0;
      r_primed       <= 1'b0;
      r_cand_off     <= 4'd0;
      r_align_off    <= 4'd0;
      r_cnt          <= 3'd0;
      r_err          <= 3'd0;
      r_data_out     <= 10'd0;
      r_data_out_vld <= 1'b0;
      r_comma_out    <= 1'b0;
      r_locked       <= 1'b0;
    end else if (data_in_vld) begin
      r_state        <= w_state_n;
      r_prev         <= data_in;
      r_primed       <= 1'b1;
      r_cand_off     <= w_cand_n;
      r_align_off    <= w_align_n;
      r_cnt          <= w_cnt_n;
      r_err          <= w_err_n;
      r_data_out     <= w_sym;
      r_data_out_vld <= (w_state_n == ST_LOCKED);
      r_comma_out    <= w_sym_comma;
      r_locked       <= (w_state_n == ST_LOCKED);
    end else begin
      r_data_out_vld <= 1'b0;
    end
  end

  assign data_out     = r_data_out;
  assign data_out_vld = r_data_out_vld;
  assign comma_out    = r_comma_out;
  assign locked       = r_locked;
  assign align_off    = r_align_off;
  assign dbg_state    = r_state;

endmodule
